// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
//   - ALU function codes (the arbiter passes them through untouched)
//   - arbiter FSM state type
package alu_pkg;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_NOTA  = 3'b101;
    localparam logic [2:0] ALU_PASSA = 3'b110;
    localparam logic [2:0] ALU_NOTB  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Ports:
//   req        in  NREQ  request vector
//   last_grant in  IDW   index granted last time; search starts one above it
//   gnt_oh     out NREQ  one-hot grant (zero when no request)
//   gnt_idx    out IDW   index of the grant (0 when no request)
//   any_vld    out 1     at least one request is present
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] gnt_oh,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any_vld
);

    logic found;
    int   idx;

    // Walk offsets 1..NREQ from the last grant; the last grant itself is
    // visited last, so a lone requester can still be granted back-to-back.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        any_vld = |req;
        found   = 1'b0;
        idx     = 0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = int'(last_grant) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[IDW'(idx)]) begin
                found               = 1'b1;
                gnt_idx             = IDW'(idx);
                gnt_oh[IDW'(idx)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one external combinational ALU among NREQ requesters.
// A granted request is registered onto alu_a/alu_b/alu_f for one EXEC cycle,
// the ALU result is captured, and it is returned with the requester ID under
// a valid/ready handshake.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req_valid/req_ready     per-requester handshake (req_ready one-hot or 0)
//   req_a/req_b/req_f       packed per-requester operands and function
//   alu_a/alu_b/alu_f       registered operands to the ALU
//   alu_r/alu_cout          ALU result and carry
//   rsp_valid/rsp_ready     response handshake
//   rsp_id/rsp_r/rsp_cout   response payload, held until accepted
//   busy                    FSM not in IDLE
//   ops_done                completed-response counter (wraps)
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*3-1:0]     req_f,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [2:0]            alu_f,
    input  logic [WIDTH-1:0]      alu_r,
    input  logic                  alu_cout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_r,
    output logic                  rsp_cout,
    output logic                  busy,
    output logic [15:0]           ops_done
);

    arb_state_t state_q, state_d;

    logic [IDW-1:0]  last_grant;
    logic [NREQ-1:0] gnt_oh;
    logic [IDW-1:0]  gnt_idx;
    logic            any_vld;
    logic [15:0]     ops_cnt;

    // Same bits as the flat ports, viewed per requester.
    logic [NREQ-1:0][WIDTH-1:0] a_vec, b_vec;
    logic [NREQ-1:0][2:0]       f_vec;

    assign a_vec    = req_a;
    assign b_vec    = req_b;
    assign f_vec    = req_f;
    assign ops_done = ops_cnt;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .gnt_oh     (gnt_oh),
        .gnt_idx    (gnt_idx),
        .any_vld    (any_vld)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_vld)   state_d = EXEC;
            EXEC:                   state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Outputs: the grant is only exposed while IDLE, so acceptance is
    // exactly req_valid[g] & req_ready[g] in that cycle.
    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                req_ready = gnt_oh;
                busy      = 1'b0;
            end
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Request capture: operands, ID and pointer update on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_f      <= ALU_ADD;
            rsp_id     <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else if (state_q == IDLE && any_vld) begin
            alu_a      <= a_vec[gnt_idx];
            alu_b      <= b_vec[gnt_idx];
            alu_f      <= f_vec[gnt_idx];
            rsp_id     <= gnt_idx;
            last_grant <= gnt_idx;
        end
    end

    // Result capture at the end of the EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_r    <= '0;
            rsp_cout <= 1'b0;
        end else if (state_q == EXEC) begin
            rsp_r    <= alu_r;
            rsp_cout <= alu_cout;
        end
    end

    // Completed-response counter; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ops_cnt <= '0;
        else if (state_q == RESP && rsp_ready)
            ops_cnt <= ops_cnt + 16'd1;
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: an external ALU model drives alu_r/alu_cout,
// a transaction-level reference checks every cycle, plus literal checks.
module tb_alu_rr_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0, req_b = '0;
    logic [N*3-1:0] req_f = '0;
    logic [W-1:0]   alu_a, alu_b, alu_r;
    logic [2:0]     alu_f;
    logic           alu_cout;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_r;
    logic           rsp_cout;
    logic           busy;
    logic [15:0]    ops_done;

    int n_chk = 0;
    int n_fail = 0;

    alu_rr_arbiter #(.NREQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_f(req_f),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .alu_r(alu_r), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_r(rsp_r), .rsp_cout(rsp_cout),
        .busy(busy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] f);
        case (f)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} + {1'b0, ~b} + 33'd1;
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, ~a};
            3'd6:    return {1'b0, a};
            default: return {1'b0, ~b};
        endcase
    endfunction

    assign {alu_cout, alu_r} = alu_model(alu_a, alu_b, alu_f);

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int i = (last + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: phase 0 = waiting for a request, 1 = operation issued,
    // 2 = result offered. Result is computed at grant time from the request.
    int          m_phase = 0;
    int          m_last = N - 1;
    int          m_id = 0;
    logic [31:0] m_a = '0, m_b = '0, m_r = '0;
    logic [2:0]  m_f = '0;
    logic        m_c = 1'b0;
    logic [32:0] m_pend = '0;
    logic [15:0] m_ops = '0;
    int          mg;
    int          cyc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_last <= N - 1; m_id <= 0;
            m_a <= '0; m_b <= '0; m_f <= '0; m_r <= '0; m_c <= 1'b0; m_ops <= '0;
        end else begin
            cyc <= cyc + 1;
            case (m_phase)
                0: begin
                    mg = pick(req_valid, m_last);
                    if (mg >= 0) begin
                        m_last  <= mg;
                        m_id    <= mg;
                        m_a     <= req_a[mg*W +: W];
                        m_b     <= req_b[mg*W +: W];
                        m_f     <= req_f[mg*3 +: 3];
                        m_pend  <= alu_model(req_a[mg*W +: W], req_b[mg*W +: W], req_f[mg*3 +: 3]);
                        m_phase <= 1;
                    end
                end
                1: begin
                    m_r <= m_pend[31:0];
                    m_c <= m_pend[32];
                    m_phase <= 2;
                end
                default: if (rsp_ready) begin
                    m_ops   <= m_ops + 16'd1;
                    m_phase <= 0;
                end
            endcase
        end
    end

    typedef struct { int id; logic [31:0] r; logic c; } rsp_t;
    rsp_t rsp_log[$];
    int   grant_log[$];
    int   grant_cyc[$];
    int   cg;
    logic [N-1:0] exp_rdy;

    always @(negedge clk) begin
        cg = pick(req_valid, m_last);
        exp_rdy = (m_phase == 0 && cg >= 0) ? N'(1 << cg) : '0;
        chk("req_ready", req_ready, exp_rdy);
        chk("rsp_valid", rsp_valid, m_phase == 2);
        chk("busy", busy, m_phase != 0);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_f", alu_f, m_f);
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_r", rsp_r, m_r);
        chk("rsp_cout", rsp_cout, m_c);
        chk("ops_done", ops_done, m_ops);
        for (int k = 0; k < N; k++)
            if (req_ready[k]) begin
                grant_log.push_back(k);
                grant_cyc.push_back(cyc);
            end
        if (rsp_valid && rsp_ready)
            rsp_log.push_back('{id: int'(rsp_id), r: rsp_r, c: rsp_cout});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Raise one request and hold it until it is accepted (bounded).
    task automatic send(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f);
        logic got;
        got = 1'b0;
        req_a[r*W +: W] = a;
        req_b[r*W +: W] = b;
        req_f[r*3 +: 3] = f;
        req_valid[r]    = 1'b1;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            got = req_ready[r];
            tick();
        end
        req_valid[r] = 1'b0;
        if (!got) chk("send timeout", 0, 1);
    endtask

    logic [31:0] sweep_r [8];

    initial begin
        sweep_r = '{32'h80000001, 32'h7FFFFFFF, 32'h00000000, 32'h80000001,
                    32'h80000001, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFE};

        // Reset values
        tick(); tick();
        chk("rst busy", busy, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst alu_a", alu_a, 0);
        chk("rst ops_done", ops_done, 0);
        rst_n = 1'b1;
        tick();

        // Single request from requester 2
        send(2, 32'h7FFFFFFF, 32'h00000001, 3'b000);
        chk("t1 exec rsp_valid", rsp_valid, 0);
        chk("t1 exec alu_a", alu_a, 32'h7FFFFFFF);
        tick();
        chk("t1 rsp_valid", rsp_valid, 1);
        chk("t1 rsp_id", rsp_id, 2);
        chk("t1 rsp_r", rsp_r, 32'h80000000);
        chk("t1 rsp_cout", rsp_cout, 0);
        tick();
        chk("t1 ops_done", ops_done, 1);

        // All requesters continuously valid
        do_reset();
        grant_log.delete(); grant_cyc.delete(); rsp_log.delete();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = $urandom;
            req_b[i*W +: W] = $urandom;
            req_f[i*3 +: 3] = 3'($urandom_range(0, 7));
        end
        req_valid = '1;
        repeat (15) tick();
        req_valid = '0;
        repeat (3) tick();
        chk("t2 grant count", grant_log.size(), 5);
        if (grant_log.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("t2 grant order", grant_log[i], i % N);
            for (int i = 0; i < 4; i++) chk("t2 grant spacing", grant_cyc[i+1] - grant_cyc[i], 3);
        end
        chk("t2 rsp count", rsp_log.size(), 5);
        if (rsp_log.size() >= 5)
            for (int i = 0; i < 5; i++) chk("t2 rsp id", rsp_log[i].id, i % N);

        // Back-pressure on requester 1's response
        rsp_ready = 1'b0;
        send(1, 32'hFFFFFFFF, 32'h00000001, 3'b000);
        req_a[0 +: W] = 32'h5; req_b[0 +: W] = 32'h3; req_f[0 +: 3] = 3'b001;
        req_valid[0] = 1'b1;
        grant_log.delete();
        repeat (10) tick();
        chk("t3 rsp_valid held", rsp_valid, 1);
        chk("t3 rsp_r held", rsp_r, 32'h0);
        chk("t3 rsp_cout held", rsp_cout, 1);
        chk("t3 rsp_id held", rsp_id, 1);
        chk("t3 no grant", grant_log.size(), 0);
        rsp_ready = 1'b1;
        for (int t = 0; t < 10 && grant_log.size() == 0; t++) tick();
        req_valid = '0;
        chk("t3 grant after release", grant_log.size() > 0 ? grant_log[0] : -1, 0);
        repeat (4) tick();

        // Function sweep from requester 3
        for (int f = 0; f < 8; f++) begin
            send(3, 32'h80000000, 32'h00000001, 3'(f));
            tick();
            chk("t4 sweep rsp_r", rsp_r, sweep_r[f]);
            tick();
        end

        // Reset while EXEC
        send(0, 32'h12345678, 32'h9, 3'b000);
        #2 rst_n = 1'b0;
        #1;
        chk("t5 busy", busy, 0);
        chk("t5 alu_a", alu_a, 0);
        chk("t5 rsp_valid", rsp_valid, 0);
        chk("t5 ops_done", ops_done, 0);
        tick();
        rst_n = 1'b1;
        grant_log.delete(); rsp_log.delete();
        req_a[3*W +: W] = 32'h1; req_b[3*W +: W] = 32'h1;
        req_valid = 4'b1001;
        tick();
        req_valid = '0;
        repeat (5) tick();
        chk("t5 grants", grant_log.size(), 1);
        chk("t5 first grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);
        chk("t5 rsp count", rsp_log.size(), 1);
        chk("t5 rsp id", rsp_log.size() > 0 ? rsp_log[0].id : -1, 0);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                req_a[i*W +: W] = $urandom;
                req_b[i*W +: W] = $urandom;
                req_f[i*3 +: 3] = 3'($urandom_range(0, 7));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (5) tick();

        // Counter wrap: preload near the top
        force dut.ops_cnt = 16'hFFFE;
        m_ops <= 16'hFFFE;
        #1 release dut.ops_cnt;
        send(2, 32'h1, 32'h2, 3'b000);
        tick(); tick();
        chk("t7 ops_done FFFF", ops_done, 16'hFFFF);
        send(2, 32'h3, 32'h4, 3'b000);
        tick(); tick();
        chk("t7 ops_done wrap", ops_done, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
